// File: rtl/mips_mem_pkg.sv
// Shared types and constants for the MIPS data-memory load path.
// Load type codes, FSM state encodings and the latency counter width.
package mips_mem_pkg;

    localparam int CNT_W = 3;

    localparam logic [2:0] LT_LW  = 3'd0;
    localparam logic [2:0] LT_LH  = 3'd1;
    localparam logic [2:0] LT_LHU = 3'd2;
    localparam logic [2:0] LT_LB  = 3'd3;
    localparam logic [2:0] LT_LBU = 3'd4;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WAIT  = 2'd1,
        S_VALID = 2'd2
    } state_t;

endpackage

// File: rtl/load_extract.sv
// Selects the addressed byte/half/word from a little-endian RAM word
// and sign- or zero-extends it to 32 bits.
module load_extract
    import mips_mem_pkg::*;
(
    input  logic [2:0]  ld_type,
    input  logic [1:0]  off,
    input  logic [31:0] mem_out,
    output logic [31:0] data
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    always_comb begin
        byte_v = mem_out[{off, 3'b000} +: 8];
        half_v = mem_out[{off[1], 4'b0000} +: 16];
        case (ld_type)
            LT_LB:   data = {{24{byte_v[7]}}, byte_v};
            LT_LBU:  data = {24'd0, byte_v};
            LT_LH:   data = {{16{half_v[15]}}, half_v};
            LT_LHU:  data = {16'd0, half_v};
            // Unused codes fall back to a full-word load.
            default: data = mem_out;
        endcase
    end

endmodule

// File: rtl/ram_load_adapter.sv
// Issues word-aligned RAM reads for MIPS loads and returns the extended
// result after RAM_LATENCY cycles; misaligned loads are flagged, not issued.
module ram_load_adapter
    import mips_mem_pkg::*;
#(
    parameter int ADDR_BITS   = 32,
    parameter int DATA_BITS   = 32,
    parameter int RAM_LATENCY = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 ld_req,
    input  logic [2:0]           ld_type,
    input  logic [31:0]          result1,
    input  logic [DATA_BITS-1:0] mem_out,
    output logic [ADDR_BITS-1:0] addr,
    output logic                 mem_rd_en,
    output logic [31:0]          load_data,
    output logic                 load_valid,
    output logic                 busy,
    output logic                 addr_err
);

    localparam logic [CNT_W-1:0] LAT = CNT_W'(RAM_LATENCY);

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [2:0]       type_q;
    logic [1:0]       off_q;
    logic [31:0]      load_data_q;
    logic             load_valid_q;
    logic             addr_err_q;

    logic             accept;
    logic             aligned;
    logic [31:0]      ext_data;

    always_comb begin
        case (ld_type)
            LT_LH, LT_LHU: aligned = ~result1[0];
            LT_LB, LT_LBU: aligned = 1'b1;
            default:       aligned = (result1[1:0] == 2'b00);
        endcase
    end

    assign accept    = ld_req && (state_q != S_WAIT);
    assign mem_rd_en = accept && aligned;
    assign addr      = ADDR_BITS'(result1 >> 2);
    assign busy      = (state_q == S_WAIT);

    load_extract u_extract (
        .ld_type (type_q),
        .off     (off_q),
        .mem_out (mem_out[31:0]),
        .data    (ext_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            type_q       <= '0;
            off_q        <= '0;
            load_data_q  <= '0;
            load_valid_q <= 1'b0;
            addr_err_q   <= 1'b0;
        end else begin
            load_valid_q <= 1'b0;
            addr_err_q   <= 1'b0;
            case (state_q)
                S_WAIT: begin
                    if (cnt_q == LAT) begin
                        load_data_q  <= ext_data;
                        load_valid_q <= 1'b1;
                        state_q      <= S_VALID;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: begin
                    if (accept && aligned) begin
                        type_q  <= ld_type;
                        off_q   <= result1[1:0];
                        cnt_q   <= CNT_W'(1);
                        state_q <= S_WAIT;
                    end else begin
                        addr_err_q <= accept;
                        state_q    <= S_IDLE;
                    end
                end
            endcase
        end
    end

    assign load_data  = load_data_q;
    assign load_valid = load_valid_q;
    assign addr_err   = addr_err_q;

endmodule

// File: tb/tb_ram_load_adapter.sv
// Directed bench for ram_load_adapter: one instance at latency 1,
// one at latency 3, sharing data inputs but with separate requests.
module tb_ram_load_adapter;

    logic        clk = 1'b0;
    logic        rst;
    logic        req1, req3;
    logic [2:0]  ld_type;
    logic [31:0] result1;
    logic [31:0] mem_out;

    logic [31:0] addr1, addr3;
    logic        rd1, rd3;
    logic [31:0] data1, data3;
    logic        val1, val3;
    logic        busy1, busy3;
    logic        err1, err3;

    int nvec = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    ram_load_adapter #(.RAM_LATENCY(1)) dut1 (
        .clk(clk), .rst(rst), .ld_req(req1), .ld_type(ld_type),
        .result1(result1), .mem_out(mem_out), .addr(addr1),
        .mem_rd_en(rd1), .load_data(data1), .load_valid(val1),
        .busy(busy1), .addr_err(err1)
    );

    ram_load_adapter #(.RAM_LATENCY(3)) dut3 (
        .clk(clk), .rst(rst), .ld_req(req3), .ld_type(ld_type),
        .result1(result1), .mem_out(mem_out), .addr(addr3),
        .mem_rd_en(rd3), .load_data(data3), .load_valid(val3),
        .busy(busy3), .addr_err(err3)
    );

    task automatic test_reset();
        @(negedge clk);
        #1;
        nvec++;
        if ({val1, err1, busy1, data1} !== 35'd0) begin
            nerr++;
            $display("FAIL reset_lat1 got v%b e%b b%b d%h want 0",
                     val1, err1, busy1, data1);
        end
        nvec++;
        if ({val3, err3, busy3, data3} !== 35'd0) begin
            nerr++;
            $display("FAIL reset_lat3 got v%b e%b b%b d%h want 0",
                     val3, err3, busy3, data3);
        end
    endtask

    task automatic test_extract();
        logic [2:0]  t_type [5] = '{3'd3, 3'd4, 3'd1, 3'd2, 3'd0};
        logic [31:0] t_adr  [5] = '{32'h100, 32'h103, 32'h102, 32'h100, 32'h100};
        logic [31:0] t_exp  [5] = '{32'hFFFFFFBB, 32'h00000088, 32'hFFFF8899,
                                    32'h0000AABB, 32'h8899AABB};
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            req1 = 1'b1; ld_type = t_type[i]; result1 = t_adr[i];
            mem_out = 32'h8899AABB;
            #1;
            nvec++;
            if (rd1 !== 1'b1 || addr1 !== 32'h40) begin
                nerr++;
                $display("FAIL extract_issue[%0d] got rd%b addr %h want rd1 addr 40",
                         i, rd1, addr1);
            end
            @(negedge clk);
            req1 = 1'b0;
            #1;
            nvec++;
            if (val1 !== 1'b0 || busy1 !== 1'b1) begin
                nerr++;
                $display("FAIL extract_wait[%0d] got v%b b%b want v0 b1",
                         i, val1, busy1);
            end
            @(negedge clk);
            #1;
            nvec++;
            if (val1 !== 1'b1 || data1 !== t_exp[i]) begin
                nerr++;
                $display("FAIL extract_data[%0d] got v%b %h want v1 %h",
                         i, val1, data1, t_exp[i]);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_misaligned();
        logic [2:0]  t_type [2] = '{3'd0, 3'd1};
        logic [31:0] t_adr  [2] = '{32'h102, 32'h101};
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            req1 = 1'b1; ld_type = t_type[i]; result1 = t_adr[i];
            #1;
            nvec++;
            if (rd1 !== 1'b0) begin
                nerr++;
                $display("FAIL misal_rd[%0d] got %b want 0", i, rd1);
            end
            @(negedge clk);
            req1 = 1'b0;
            #1;
            nvec++;
            if (err1 !== 1'b1 || val1 !== 1'b0 || busy1 !== 1'b0) begin
                nerr++;
                $display("FAIL misal_err[%0d] got e%b v%b b%b want e1 v0 b0",
                         i, err1, val1, busy1);
            end
            @(negedge clk);
            #1;
            nvec++;
            if (err1 !== 1'b0 || val1 !== 1'b0) begin
                nerr++;
                $display("FAIL misal_after[%0d] got e%b v%b want e0 v0",
                         i, err1, val1);
            end
        end
    endtask

    task automatic test_latency3();
        @(negedge clk);
        req3 = 1'b1; ld_type = 3'd0; result1 = 32'h0;
        mem_out = 32'hDEADBEEF;
        #1;
        nvec++;
        if (rd3 !== 1'b1 || addr3 !== 32'h0) begin
            nerr++;
            $display("FAIL lat3_issue got rd%b addr %h want rd1 addr 0", rd3, addr3);
        end
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            req3 = (c < 3); ld_type = 3'd0; result1 = 32'h4;
            mem_out = (c == 3) ? 32'h12345678 : 32'hDEADBEEF;
            #1;
            nvec++;
            if (busy3 !== 1'b1 || rd3 !== 1'b0 || val3 !== 1'b0) begin
                nerr++;
                $display("FAIL lat3_wait[%0d] got b%b rd%b v%b want b1 rd0 v0",
                         c, busy3, rd3, val3);
            end
        end
        @(negedge clk);
        req3 = 1'b0; mem_out = 32'hDEADBEEF;
        #1;
        nvec++;
        if (val3 !== 1'b1 || data3 !== 32'h12345678) begin
            nerr++;
            $display("FAIL lat3_data got v%b %h want v1 12345678", val3, data3);
        end
        @(negedge clk);
        #1;
        nvec++;
        if (val3 !== 1'b0 || data3 !== 32'h12345678) begin
            nerr++;
            $display("FAIL lat3_hold got v%b %h want v0 12345678", val3, data3);
        end
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        req1 = 1'b1; ld_type = 3'd0; result1 = 32'h100;
        @(negedge clk);
        req1 = 1'b0; mem_out = 32'hCAFEF00D;
        @(negedge clk);
        req1 = 1'b1; ld_type = 3'd0; result1 = 32'h200;
        mem_out = 32'h0BADBEEF;
        #1;
        nvec++;
        if (val1 !== 1'b1 || data1 !== 32'hCAFEF00D || rd1 !== 1'b1 ||
            addr1 !== 32'h80) begin
            nerr++;
            $display("FAIL b2b_first got v%b %h rd%b addr %h want v1 cafef00d rd1 80",
                     val1, data1, rd1, addr1);
        end
        @(negedge clk);
        req1 = 1'b0;
        #1;
        nvec++;
        if (val1 !== 1'b0 || busy1 !== 1'b1) begin
            nerr++;
            $display("FAIL b2b_gap got v%b b%b want v0 b1", val1, busy1);
        end
        @(negedge clk);
        #1;
        nvec++;
        if (val1 !== 1'b1 || data1 !== 32'h0BADBEEF) begin
            nerr++;
            $display("FAIL b2b_second got v%b %h want v1 0badbeef", val1, data1);
        end
    endtask

    task automatic test_reset_abort();
        @(negedge clk);
        req3 = 1'b1; ld_type = 3'd0; result1 = 32'h0;
        mem_out = 32'h55555555;
        @(negedge clk);
        req3 = 1'b0; rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        nvec++;
        if ({val3, err3, busy3, data3} !== 35'd0) begin
            nerr++;
            $display("FAIL abort_reset got v%b e%b b%b d%h want 0",
                     val3, err3, busy3, data3);
        end
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            #1;
            nvec++;
            if (val3 !== 1'b0 || busy3 !== 1'b0) begin
                nerr++;
                $display("FAIL abort_quiet[%0d] got v%b b%b want v0 b0",
                         c, val3, busy3);
            end
        end
        @(negedge clk);
        req3 = 1'b1; ld_type = 3'd3; result1 = 32'h101;
        mem_out = 32'h8899AABB;
        @(negedge clk);
        req3 = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        nvec++;
        if (val3 !== 1'b0) begin
            nerr++;
            $display("FAIL relb_early got v%b want v0", val3);
        end
        @(negedge clk);
        #1;
        nvec++;
        if (val3 !== 1'b1 || data3 !== 32'hFFFFFFAA) begin
            nerr++;
            $display("FAIL relb_data got v%b %h want v1 ffffffaa", val3, data3);
        end
    endtask

    initial begin
        rst = 1'b1; req1 = 1'b0; req3 = 1'b0;
        ld_type = 3'd0; result1 = 32'h0; mem_out = 32'h0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        test_reset();
        test_extract();
        test_misaligned();
        test_latency3();
        test_back_to_back();
        test_reset_abort();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
